// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: state encodings, channel count, select width.
// Imported by the RTL and by the testbench.
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } scan_state_e;

    // True when the select points at the highest-numbered channel of a sweep.
    function automatic logic is_last_ch(input logic [SEL_W-1:0] sel);
        return (sel == SEL_W'(NUM_CH - 1));
    endfunction

    // Even parity over a snapshot word, available to consumers guarding the snapshot bus.
    function automatic logic snap_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake / mux-facing bundle of the scan controller.
// master = controller side, slave = mux + downstream consumer side.
interface mux_scan_ctrl_if #(
    parameter int WIDTH = 2
);
    import mux_scan_ctrl_pkg::*;

    logic                      start;
    logic                      cont;
    logic                      stop;
    logic [WIDTH-1:0]          y_in;
    logic [SEL_W-1:0]          mux_sel;
    logic                      mux_en;
    logic [NUM_CH*WIDTH-1:0]   scan_data;
    logic                      scan_valid;
    logic                      busy;
    logic                      done;
    logic                      chg;

    modport master (
        input  start, cont, stop, y_in,
        output mux_sel, mux_en, scan_data, scan_valid, busy, done, chg
    );

    modport slave (
        output start, cont, stop, y_in,
        input  mux_sel, mux_en, scan_data, scan_valid, busy, done, chg
    );

endinterface

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable dwell counter with a terminal-count flag raised when the count equals TERM.
module mux_scan_dwell_cnt #(
    parameter int CNT_W = 8,
    parameter int TERM  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins over increment, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == CNT_W'(TERM));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin sequencer for a 4:1 channel mux: settles DWELL cycles per channel, captures Y into a snapshot.
// Optional macro MUX_SCAN_CHG_EN builds the snapshot-changed flag; otherwise chg is tied low.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mux_scan_ctrl_if.master        bus
);

    localparam int SNAP_W = NUM_CH * WIDTH;

    generate
        if ((DWELL < 1) || (DWELL >= (1 << CNT_W))) begin : g_bad_dwell
            $error("mux_scan_ctrl: DWELL must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    scan_state_e       state_r, state_s;
    logic [SEL_W-1:0]  sel_r, sel_s;
    logic              en_r, en_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              valid_r, valid_s;
    logic              cont_r, cont_s;
    logic [SNAP_W-1:0] shadow_r, shadow_s;
    logic [SNAP_W-1:0] data_r, data_s;
    logic [SNAP_W-1:0] snap_s;
    logic              cnt_load_s;
    logic              cnt_inc_s;
    logic              cnt_tc_s;

    mux_scan_dwell_cnt #(
        .CNT_W (CNT_W),
        .TERM  (DWELL - 1)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val ({CNT_W{1'b0}}),
        .inc      (cnt_inc_s),
        .tc       (cnt_tc_s)
    );

    // Completed snapshot: collected slots plus the last channel sampled straight from Y.
    always_comb begin
        snap_s = shadow_r;
        snap_s[(NUM_CH-1)*WIDTH +: WIDTH] = bus.y_in;
    end

    // Next-state and next-output logic of the scan FSM.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        en_s       = en_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        valid_s    = valid_r;
        cont_s     = cont_r;
        shadow_s   = shadow_r;
        data_s     = data_r;
        cnt_load_s = 1'b1;
        cnt_inc_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_s  = ST_SETTLE;
                    sel_s    = '0;
                    en_s     = 1'b1;
                    busy_s   = 1'b1;
                    cont_s   = bus.cont;
                    shadow_s = '0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (bus.stop) begin
                    state_s  = ST_IDLE;
                    sel_s    = '0;
                    en_s     = 1'b0;
                    busy_s   = 1'b0;
                    shadow_s = '0;
                end else if (cnt_tc_s) begin
                    state_s  = ST_CAPTURE;
                end else begin
                    cnt_load_s = 1'b0;
                    cnt_inc_s  = 1'b1;
                end
            end

            ST_CAPTURE: begin
                // A stop here beats the final capture: the sweep never completes.
                if (bus.stop) begin
                    state_s  = ST_IDLE;
                    sel_s    = '0;
                    en_s     = 1'b0;
                    busy_s   = 1'b0;
                    shadow_s = '0;
                end else if (!is_last_ch(sel_r)) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        shadow_s[k*WIDTH +: WIDTH] = (sel_r == SEL_W'(k)) ? bus.y_in
                                                                          : shadow_r[k*WIDTH +: WIDTH];
                    end
                    sel_s   = sel_r + SEL_W'(1);
                    state_s = ST_SETTLE;
                end else begin
                    data_s   = snap_s;
                    valid_s  = 1'b1;
                    done_s   = 1'b1;
                    shadow_s = '0;
                    sel_s    = '0;
                    if (cont_r) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                        en_s    = 1'b0;
                        busy_s  = 1'b0;
                    end
                end
            end

            default: begin
                state_s  = ST_IDLE;
                sel_s    = '0;
                en_s     = 1'b0;
                busy_s   = 1'b0;
                shadow_s = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sel_r    <= '0;
            en_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            cont_r   <= 1'b0;
            shadow_r <= '0;
            data_r   <= '0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            en_r     <= en_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            valid_r  <= valid_s;
            cont_r   <= cont_s;
            shadow_r <= shadow_s;
            data_r   <= data_s;
        end
    end

`ifdef MUX_SCAN_CHG_EN
    logic chg_r, chg_s;

    // The outgoing scan_data is the previous snapshot, so no extra history register is needed.
    always_comb begin
        chg_s = done_s && (snap_s != data_r);
    end

    // Change flag register, aligned with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= chg_s;
        end
    end

    assign bus.chg = chg_r;
`else
    assign bus.chg = 1'b0;
`endif

    assign bus.mux_sel    = sel_r;
    assign bus.mux_en     = en_r;
    assign bus.scan_data  = data_r;
    assign bus.scan_valid = valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: models the 4:1 mux and predicts sweeps from timing rules.
module tb_mux_scan_ctrl;
    import mux_scan_ctrl_pkg::*;

    localparam int WIDTH  = 2;
    localparam int DWELL  = 2;
    localparam int PER    = DWELL + 1;
    localparam int LAT    = NUM_CH * PER;
    localparam int SNAP_W = NUM_CH * WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mux_scan_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] ch [NUM_CH];
    always_comb bus.y_in = bus.mux_en ? ch[bus.mux_sel] : '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [SNAP_W-1:0] exp_snap;
    logic              exp_valid;

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SNAP_W-1:0] model_snap();
        logic [SNAP_W-1:0] s;
        for (int k = 0; k < NUM_CH; k++) s[k*WIDTH +: WIDTH] = ch[k];
        return s;
    endfunction

    task automatic set_ch(input logic [WIDTH-1:0] a, b, c, d);
        ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
    endtask

    task automatic rand_ch();
        for (int k = 0; k < NUM_CH; k++) ch[k] = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        exp_snap  = '0;
        exp_valid = 1'b0;
    endtask

    // Drives one sweep (optionally starting it) and checks every cycle up to and including done.
    task automatic run_sweep(input bit cont_mode, input bit issue_start, input int glitch_n);
        logic [SNAP_W-1:0] snap;
        logic              exp_chg;
        if (issue_start) begin
            bus.start = 1'b1; bus.cont = cont_mode;
            tick();
            bus.start = 1'b0; bus.cont = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.mux_en !== 1'b1 || bus.mux_sel !== 2'd0) begin
                errors++;
                $display("FAIL accept busy=%0b en=%0b sel=%0d required 1 1 0", bus.busy, bus.mux_en, bus.mux_sel);
            end
        end
        snap = model_snap();
`ifdef MUX_SCAN_CHG_EN
        exp_chg = (snap != exp_snap);
`else
        exp_chg = 1'b0;
`endif
        for (int n = 1; n <= LAT; n++) begin
            if (n == glitch_n) begin bus.start = 1'b1; bus.cont = ~cont_mode; end
            tick();
            bus.start = 1'b0; bus.cont = 1'b0;
            checks++;
            if (n < LAT) begin
                if (bus.mux_sel !== 2'(n / PER) || bus.mux_en !== 1'b1 || bus.busy !== 1'b1 ||
                    bus.done !== 1'b0 || bus.chg !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_cycle n=%0d sel=%0d en=%0b busy=%0b done=%0b chg=%0b required sel=%0d 1 1 0 0",
                             n, bus.mux_sel, bus.mux_en, bus.busy, bus.done, bus.chg, n / PER);
                end
            end else begin
                if (bus.done !== 1'b1 || bus.busy !== cont_mode || bus.mux_en !== cont_mode ||
                    bus.scan_data !== snap || bus.scan_valid !== 1'b1 || bus.chg !== exp_chg ||
                    (cont_mode && bus.mux_sel !== 2'd0)) begin
                    errors++;
                    $display("FAIL sweep_done done=%0b busy=%0b en=%0b sel=%0d data=%b valid=%0b chg=%0b required 1 %0b %0b data=%b 1 chg=%0b",
                             bus.done, bus.busy, bus.mux_en, bus.mux_sel, bus.scan_data, bus.scan_valid,
                             bus.chg, cont_mode, cont_mode, snap, exp_chg);
                end
            end
        end
        exp_snap  = snap;
        exp_valid = 1'b1;
    endtask

    // Checks the controller is idle with the model's last completed snapshot.
    task automatic check_idle(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.mux_en !== 1'b0 || bus.mux_sel !== 2'd0 || bus.done !== 1'b0 ||
            bus.scan_data !== exp_snap || bus.scan_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s busy=%0b en=%0b sel=%0d done=%0b data=%b valid=%0b required 0 0 0 0 data=%b valid=%0b",
                     tag, bus.busy, bus.mux_en, bus.mux_sel, bus.done, bus.scan_data, bus.scan_valid,
                     exp_snap, exp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.mux_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_en cycle=%0d got %0b required 0", i, bus.mux_en);
            end
        end
        rst = 1'b0;
        exp_snap = '0; exp_valid = 1'b0;
        checks++;
        if (bus.mux_sel !== 2'd0 || bus.scan_data !== '0 || bus.scan_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_values sel=%0d data=%b valid=%0b busy=%0b done=%0b chg=%0b required all 0",
                     bus.mux_sel, bus.scan_data, bus.scan_valid, bus.busy, bus.done, bus.chg);
        end
    endtask

    task automatic test_single_sweep();
        set_ch(2'b01, 2'b00, 2'b10, 2'b11);
        run_sweep(1'b0, 1'b1, 0);
        checks++;
        if (bus.scan_data !== 8'b11_10_00_01) begin
            errors++;
            $display("FAIL single_data got %b required 11100001", bus.scan_data);
        end
        tick();
        check_idle("single_after");
    endtask

    task automatic test_continuous();
        do_reset();
        set_ch(2'b01, 2'b00, 2'b10, 2'b11);
        run_sweep(1'b1, 1'b1, 0);
        ch[2] = 2'b01;
        run_sweep(1'b1, 1'b0, 0);
        checks++;
        if (bus.scan_data !== 8'b11_01_00_01) begin
            errors++;
            $display("FAIL cont_data got %b required 11010001", bus.scan_data);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("cont_stop");
    endtask

    task automatic test_stop();
        int dc;
        rand_ch();
        run_sweep(1'b0, 1'b1, 0);
        tick();
        for (int k = 0; k < NUM_CH; k++) ch[k] = ~ch[k];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dc = done_cnt;
        for (int n = 1; n <= 2 * PER; n++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("stop_mid");
        repeat (LAT) tick();
        check_idle("stop_hold");
        checks++;
        if (done_cnt !== dc) begin
            errors++;
            $display("FAIL stop_done_count got %0d required %0d", done_cnt, dc);
        end
    endtask

    task automatic test_collisions();
        int dc;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_idle("start_stop_idle");
        tick();
        check_idle("start_stop_idle2");
        rand_ch();
        dc = done_cnt;
        run_sweep(1'b0, 1'b1, 4);
        tick();
        checks++;
        if (done_cnt !== dc + 1) begin
            errors++;
            $display("FAIL busy_start_done_count got %0d required %0d", done_cnt, dc + 1);
        end
        for (int k = 0; k < NUM_CH; k++) ch[k] = ~ch[k];
        dc = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n < LAT; n++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("stop_final_capture");
        tick();
        checks++;
        if (done_cnt !== dc) begin
            errors++;
            $display("FAIL final_stop_done_count got %0d required %0d", done_cnt, dc);
        end
    endtask

    task automatic test_reset_mid();
        set_ch(2'b10, 2'b01, 2'b11, 2'b01);
        run_sweep(1'b0, 1'b1, 0);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= PER; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_snap = '0; exp_valid = 1'b0;
        check_idle("reset_mid");
        checks++;
        if (bus.chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_chg got %0b required 0", bus.chg);
        end
        run_sweep(1'b0, 1'b1, 0);
        tick();
        check_idle("reset_mid_fresh");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            if (it != 0) rand_ch();
            if ($urandom_range(0, 1) == 1) begin
                run_sweep(1'b1, 1'b1, int'($urandom_range(0, LAT - 1)));
                rand_ch();
                run_sweep(1'b1, 1'b0, 0);
                bus.stop = 1'b1;
                tick();
                bus.stop = 1'b0;
            end else begin
                run_sweep(1'b0, 1'b1, int'($urandom_range(0, LAT - 1)));
                tick();
            end
            check_idle("random_idle");
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.cont = 1'b0; bus.stop = 1'b0;
        set_ch(2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        test_reset();
        test_single_sweep();
        test_continuous();
        test_stop();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
